pow_n_seq: RTL and testbench

Sequential runtime-exponent power unit computing `n_pow = n ** exp` modulo 2^WIDTH by right-to-left square-and-multiply. It is the parametrised successor to the fixed fifth-power units. Width and exponent range are compile-time parameters, and the exponent is chosen per operation. It sits in the arithmetic datapath behind a valid/ready handshake on both sides, so it can be chained or fed from a FIFO without external sequencing.

---
 rtl/pow_n_seq.sv | 114 +++++++++++
 tb/tb_pow_n_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_n_seq.sv
// pow_n_seq: sequential n**exp modulo 2^WIDTH using right-to-left square-and-multiply.
// A valid/ready handshake is used on both the request side and the result side.
// Optional feature macro: POW_N_SEQ_OVERFLOW_EN.
//   Defined:   the overflow output reports that the exact power did not fit in WIDTH bits.
//   Undefined: overflow is tied to 0.
module pow_n_seq #(
  parameter int WIDTH     = 18,
  parameter int EXP_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     n,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     n_pow,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_e;
  logic [WIDTH-1:0]     w_accLo;
  logic [WIDTH-1:0]     w_baseLo;
  logic                 w_accept;
  logic                 w_step;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_step    = (r_state == RUN) && (r_e != '0);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign n_pow     = r_acc;

`ifdef POW_N_SEQ_OVERFLOW_EN
  logic [2*WIDTH-1:0] w_accProd;
  logic [2*WIDTH-1:0] w_baseProd;
  logic               w_ovfHit;
  logic               r_ovf;

  assign w_accProd  = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_base};
  assign w_baseProd = {{WIDTH{1'b0}}, r_base} * {{WIDTH{1'b0}}, r_base};
  assign w_accLo    = w_accProd[WIDTH-1:0];
  assign w_baseLo   = w_baseProd[WIDTH-1:0];
  // A square only matters if a later step will still use it, hence the e>>1 qualifier.
  assign w_ovfHit   = (r_e[0] && (w_accProd[2*WIDTH-1:WIDTH] != '0)) ||
                      (((r_e >> 1) != '0) && (w_baseProd[2*WIDTH-1:WIDTH] != '0));
  assign overflow   = r_ovf;

  // Sticky truncation flag: cleared on accept, set by any significant lost high half.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_step && w_ovfHit) begin
      r_ovf <= 1'b1;
    end
  end
`else
  assign w_accLo  = r_acc * r_base;
  assign w_baseLo = r_base * r_base;
  assign overflow = 1'b0;
`endif

  // State register; reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: RUN lasts until every exponent bit has been consumed.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_nextState = RUN;
      RUN:     if (r_e == '0)  w_nextState = DONE;
      DONE:    if (out_ready)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then one square-and-multiply step per clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_base <= '0;
      r_e    <= '0;
    end else if (w_accept) begin
      r_acc  <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_base <= n;
      r_e    <= exp;
    end else if (w_step) begin
      if (r_e[0]) begin
        r_acc <= w_accLo;
      end
      r_base <= w_baseLo;
      r_e    <= r_e >> 1;
    end
  end

endmodule

// File: tb/tb_pow_n_seq.sv
// tb_pow_n_seq: scoreboard bench for pow_n_seq (WIDTH=18, EXP_WIDTH=4).
// Honours POW_N_SEQ_OVERFLOW_EN when computing the expected overflow flag.
module tb_pow_n_seq;

  localparam int W  = 18;
  localparam int EW = 4;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  n;
  logic [EW-1:0] exp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  n_pow;
  logic          overflow;

  typedef struct {
    logic [W-1:0] val;
    logic         ovf;
    int           acceptEdge;
    int           lat;
  } expect_t;

  expect_t sb[$];
  int      total = 0;
  int      bad = 0;
  int      cycleCount = 0;
  int      lastHandshakeEdge = -1;
  bit      prevValid = 0;
  bit      randReady = 0;

  pow_n_seq #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .exp(exp), .out_valid(out_valid), .out_ready(out_ready),
    .n_pow(n_pow), .overflow(overflow)
  );

  // Free-running clock and edge counter
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycleCount++;

  // Random result-side backpressure when enabled
  always @(posedge clock) begin
    #1;
    if (randReady) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain repeated multiplication, with a capped exact value for the overflow flag
  function automatic expect_t model(input logic [W-1:0] nn, input logic [EW-1:0] ee);
    expect_t     r;
    longint unsigned modv = 1;
    longint unsigned capv = 1;
    longint unsigned lim = 64'd1 << W;
    int          bits = 0;
    int          x = ee;
    for (int i = 0; i < ee; i++) begin
      modv = (modv * nn) % lim;
      capv = capv * nn;
      if (capv >= lim) capv = lim;
    end
    while (x > 0) begin
      bits++;
      x = x >> 1;
    end
    r.val = modv[W-1:0];
`ifdef POW_N_SEQ_OVERFLOW_EN
    r.ovf = (capv >= lim);
`else
    r.ovf = 1'b0;
`endif
    r.lat = bits + 1;
    r.acceptEdge = 0;
    return r;
  endfunction

  // Monitor: compares every presented result against the head of the scoreboard
  always @(negedge clock) begin
    if (!reset_n) begin
      prevValid = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          if (!prevValid)
            checkOutput("latency", cycleCount - sb[0].acceptEdge, sb[0].lat);
          checkOutput("n_pow", n_pow, sb[0].val);
          checkOutput("overflow", overflow, sb[0].ovf);
          if (out_ready) begin
            void'(sb.pop_front());
            lastHandshakeEdge = cycleCount + 1;
          end
        end
      end
      prevValid = out_valid;
    end
  end

  // Present one request and hold it until accepted; returns the accept edge number
  task automatic applyStimulus(input logic [W-1:0] nn, input logic [EW-1:0] ee, output int acceptEdge);
    expect_t e;
    bit accepted = 0;
    acceptEdge = -1;
    in_valid = 1;
    n = nn;
    exp = ee;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) begin
        e = model(nn, ee);
        e.acceptEdge = cycleCount + 1;
        acceptEdge = e.acceptEdge;
        sb.push_back(e);
        accepted = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  logic [W-1:0]  dirN[9] = '{18'd3, 18'd7, 18'd0, 18'd0, 18'd10, 18'd2, 18'd512, 18'd1, 18'd262143};
  logic [EW-1:0] dirE[9] = '{4'd5, 4'd0, 4'd0, 4'd9, 4'd6, 4'd15, 4'd2, 4'd15, 4'd2};

  initial begin
    int acc;
    reset_n   = 0;
    in_valid  = 0;
    out_ready = 1;
    n         = '0;
    exp       = '0;
    #3;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_n_pow", n_pow, 0);
    checkOutput("reset_overflow", overflow, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    @(posedge clock);
    #1;

    // Directed cases, including zero exponent, zero base and truncation
    for (int k = 0; k < 9; k++) begin
      applyStimulus(dirN[k], dirE[k], acc);
      if (k == 0) begin
        @(negedge clock);
        checkOutput("busy_in_ready", in_ready, 0);
      end
      waitDrain();
    end

    // Backpressure: result held while inputs churn
    out_ready = 0;
    applyStimulus(18'd5, 4'd3, acc);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    repeat (5) begin
      @(posedge clock);
      #1;
      n = $urandom;
      exp = $urandom;
      in_valid = $urandom_range(0, 1);
      @(negedge clock);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    @(posedge clock);
    #1;
    out_ready = 1;
    applyStimulus(18'd9, 4'd4, acc);
    checkOutput("bp_next_accept", acc, lastHandshakeEdge + 1);
    waitDrain();

    // Reset two clocks into a long operation
    applyStimulus(18'd3, 4'd15, acc);
    @(posedge clock);
    #1;
    reset_n = 0;
    sb.delete();
    #1;
    checkOutput("midrun_in_ready", in_ready, 1);
    checkOutput("midrun_out_valid", out_valid, 0);
    checkOutput("midrun_n_pow", n_pow, 0);
    checkOutput("midrun_overflow", overflow, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    repeat (8) begin
      @(negedge clock);
      checkOutput("no_valid_after_reset", out_valid, 0);
    end
    @(posedge clock);
    #1;
    applyStimulus(18'd6, 4'd7, acc);
    waitDrain();

    // Random stream with random gaps and backpressure
    randReady = 1;
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0]  rn;
      logic [EW-1:0] re;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      rn = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      re = EW'($urandom);
      applyStimulus(rn, re, acc);
    end
    waitDrain();
    randReady = 0;
    out_ready = 1;
    repeat (3) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
